// File: rtl/tt_cpu8_pkg.sv
// Shared opcodes, sequencer state encoding and instruction field helpers for the CPU8 program sequencer.
// Instruction word layout: [3:0] opcode, [7:4] operand.
package tt_cpu8_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [3:0] instr_op(input logic [7:0] word);
        return word[3:0];
    endfunction

    function automatic logic [3:0] instr_arg(input logic [7:0] word);
        return word[7:4];
    endfunction

endpackage

// File: rtl/tt_cpu8_prog_ram.sv
// Program store: DEPTH x 8, synchronous write, asynchronous read, no reset.
// Read data follows raddr combinationally so a word written this cycle is visible next cycle.
module tt_cpu8_prog_ram #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/tt_cpu8_program_sequencer.sv
// Feeds the CPU8 one program word per cycle, drains its 2-stage pipeline, then captures the accumulator.
// Optional SEQ_LOOP_EN adds loop_cnt[3:0]: the program is replayed loop_cnt+1 times before draining.
module tt_cpu8_program_sequencer
    import tt_cpu8_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
`ifdef SEQ_LOOP_EN
    input  logic [3:0]    loop_cnt,
`endif
    input  logic [7:0]    acc_in,
    output logic [7:0]    instr_out,
    output logic          busy,
    output logic          done,
    output logic [7:0]    result
);

    localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PC_ONE  = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [3:0]    loop_q, loop_d;
    logic          drain_q, drain_d;
    logic [7:0]    result_q, result_d;
    logic [7:0]    rd_word;
    logic          ram_we;
    logic          is_last;
    logic          is_halt;

    assign ram_we = wr_en && (state_q == ST_IDLE) && !rst;

    tt_cpu8_prog_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (pc_q),
        .rdata (rd_word)
    );

    assign is_last = ({1'b0, pc_q} == (len_q - LEN_ONE));
    assign is_halt = (instr_op(rd_word) == OP_HALT);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        len_d     = len_q;
        loop_d    = loop_q;
        drain_d   = drain_q;
        result_d  = result_q;
        instr_out = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    drain_d = 1'b0;
                    len_d   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
`ifdef SEQ_LOOP_EN
                    loop_d  = loop_cnt;
`else
                    loop_d  = 4'd0;
`endif
                    state_d = (len_d == '0) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // HALT is consumed here and never reaches the CPU; it also cancels any remaining passes.
                if (is_halt) begin
                    state_d = ST_DRAIN;
                end else begin
                    instr_out = rd_word;
                    if (!is_last) begin
                        pc_d = pc_q + PC_ONE;
                    end else if (loop_q != 4'd0) begin
                        pc_d   = '0;
                        loop_d = loop_q - 4'd1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q) begin
                    result_d = acc_in;
                    state_d  = ST_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            loop_q   <= 4'd0;
            drain_q  <= 1'b0;
            result_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            loop_q   <= loop_d;
            drain_q  <= drain_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_tt_cpu8_program_sequencer.sv
// Bench for tt_cpu8_program_sequencer with a small accumulator CPU model attached.
// Build with +define+SEQ_LOOP_EN to exercise multi-pass replay.
module tb_tt_cpu8_program_sequencer;
    import tt_cpu8_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = 8'h00;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
`ifdef SEQ_LOOP_EN
    logic [3:0]    loop_cnt = 4'd0;
`endif
    logic [7:0]    acc_in;
    logic [7:0]    instr_out;
    logic          busy;
    logic          done;
    logic [7:0]    result;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem_m [DEPTH];
    logic [7:0] exp_acc = 8'h00;

    tt_cpu8_program_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .prog_len  (prog_len),
        .start     (start),
`ifdef SEQ_LOOP_EN
        .loop_cnt  (loop_cnt),
`endif
        .acc_in    (acc_in),
        .instr_out (instr_out),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu(input logic [7:0] acc, input logic [7:0] w);
        logic [7:0] arg;
        arg = {4'h0, w[7:4]};
        case (w[3:0])
            OP_ADD:  return acc + arg;
            OP_SUB:  return acc - arg;
            OP_AND:  return acc & arg;
            OP_OR:   return acc | arg;
            OP_NOT:  return ~acc;
            default: return acc;
        endcase
    endfunction

    // CPU: latches instr_out at the end of cycle t, executes at the end of t+1.
    logic       cpu_rst = 1'b1;
    logic [7:0] cpu_acc;
    logic [7:0] cpu_ir;
    always @(posedge clk) begin
        if (cpu_rst) begin
            cpu_acc <= 8'h00;
            cpu_ir  <= 8'h00;
        end else begin
            cpu_acc <= alu(cpu_acc, cpu_ir);
            cpu_ir  <= instr_out;
        end
    end
    assign acc_in = cpu_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_addr = addr[AW-1:0];
        wr_data = data;
        tick();
        wr_en   = 1'b0;
        mem_m[addr] = data;
    endtask

    task automatic cpu_reset();
        cpu_rst = 1'b1;
        tick();
        cpu_rst = 1'b0;
        exp_acc = 8'h00;
    endtask

    // Reference: expected instr_out per cycle after start, expected result and done cycle.
    task automatic run(input string tag, input int len, input int loops, input bit sw,
                       input logic [7:0] sw_dat, input int inject);
        logic [7:0] trace [$];
        logic [7:0] acc;
        int lenef;
        int lp;
        int c;
        bit halted;
        bit seen;
        trace  = {};
        acc    = exp_acc;
        halted = 1'b0;
        lp     = 0;
`ifdef SEQ_LOOP_EN
        lp       = loops;
        loop_cnt = loops[3:0];
`endif
        if (sw) mem_m[0] = sw_dat;
        lenef = (len > DEPTH) ? DEPTH : len;
        if (lenef > 0) begin
            for (int p = 0; p <= lp && !halted; p++) begin
                for (int i = 0; i < lenef; i++) begin
                    if (mem_m[i][3:0] == OP_HALT) begin
                        trace.push_back(8'h00);
                        halted = 1'b1;
                        break;
                    end
                    trace.push_back(mem_m[i]);
                    acc = alu(acc, mem_m[i]);
                end
            end
        end
        trace.push_back(8'h00);
        trace.push_back(8'h00);

        prog_len = len[AW:0];
        start    = 1'b1;
        wr_en    = sw;
        wr_addr  = '0;
        wr_data  = sw_dat;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        seen  = 1'b0;
        for (c = 1; c <= 400; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (c <= trace.size()) begin
                check({tag, "_instr"}, instr_out, trace[c-1]);
                check({tag, "_busy"}, busy, 1);
            end else begin
                check({tag, "_late_done"}, c, trace.size() + 1);
                break;
            end
            if (c == inject) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = 8'h91;
            end
            tick();
            start = 1'b0;
            wr_en = 1'b0;
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_done_cycle"}, c, trace.size() + 1);
        check({tag, "_result"}, result, acc);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_instr_at_done"}, instr_out, 0);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_result_hold"}, result, acc);
        exp_acc = acc;
    endtask

    initial begin
        logic [7:0] w;
        bit saw_done;
        tick();
        tick();
        check("rst_instr", instr_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        rst = 1'b0;
        cpu_reset();

        load_word(0, 8'h31);
        load_word(1, 8'h51);
        load_word(2, 8'h22);
        run("t1", 3, 0, 0, 8'h00, 0);
        check("t1_abs", result, 8'h06);

        cpu_reset();
        load_word(0, 8'h05);
        run("t2a", 1, 0, 0, 8'h00, 0);
        check("t2a_abs", result, 8'hFF);
        load_word(0, 8'hF3);
        run("t2b", 1, 0, 0, 8'h00, 0);
        check("t2b_abs", result, 8'h0F);

        cpu_reset();
        load_word(0, 8'h11);
        load_word(1, 8'h0F);
        load_word(2, 8'h71);
        run("t3", 3, 0, 0, 8'h00, 0);
        check("t3_abs", result, 8'h01);

        cpu_reset();
        run("t4", 3, 0, 0, 8'h00, 2);
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (done || busy) saw_done = 1'b1;
            tick();
        end
        check("t4_no_restart", saw_done, 0);
        cpu_reset();
        run("t4_rerun", 3, 0, 0, 8'h00, 0);
        check("t4_ram_kept", result, 8'h01);
        run("t4_len0", 0, 0, 0, 8'h00, 0);

        cpu_reset();
        load_word(0, 8'h11);
        load_word(1, 8'h21);
        load_word(2, 8'h31);
        prog_len = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_w0", instr_out, 8'h11);
        tick();
        check("t5_w1", instr_out, 8'h21);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_instr", instr_out, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_result", result, 0);
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        check("t5_no_done", saw_done, 0);
        cpu_reset();
        run("t5_rerun", 3, 0, 0, 8'h00, 0);
        check("t5_abs", result, 8'h06);

`ifdef SEQ_LOOP_EN
        cpu_reset();
        load_word(0, 8'h11);
        run("t6", 1, 3, 0, 8'h00, 0);
        check("t6_abs", result, 8'h04);
`endif

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w = 8'($urandom);
                if (w[3:0] == OP_HALT && $urandom_range(0, 2) != 0) w[3:0] = OP_ADD;
                load_word(i, w);
            end
            w = 8'($urandom);
            if (w[3:0] == OP_HALT) w[3:0] = OP_SUB;
            run("rnd", $urandom_range(0, 2 * DEPTH - 1), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), w, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
